// File: rtl/layer_pkg.sv
// Shared definitions for the CNN layer-input blocks.
// Provides the window-reader state encoding, a width helper that never
// returns zero, and the output-map size formula so that every layer in the
// pipeline derives its geometry from the same expression.
package layer_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    // Bits needed to count 0..v-1; at least one bit.
    function automatic int cw(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Number of window positions along one axis.
    function automatic int out_dim(input int in_sz, input int k, input int s, input int p);
        return (in_sz + 2 * p - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv_pp_ram.sv
// Simple dual-port RAM holding both ping-pong banks.
// Ports:
//   clk_i   - clock
//   wea_i   - write enable, port A
//   addra_i - write address
//   dina_i  - write data
//   enb_i   - read enable, port B; the output register holds when low
//   addrb_i - read address
//   doutb_o - registered read data (one-cycle latency)
module conv_pp_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 32,
    parameter int AW1   = 5
) (
    input  logic                 clk_i,
    input  logic                 wea_i,
    input  logic [AW1-1:0]       addra_i,
    input  logic signed [DW-1:0] dina_i,
    input  logic                 enb_i,
    input  logic [AW1-1:0]       addrb_i,
    output logic signed [DW-1:0] doutb_o
);

    logic signed [DW-1:0] mem_q [DEPTH];
    logic signed [DW-1:0] dout_q;

    always_ff @(posedge clk_i) begin
        if (wea_i) mem_q[addra_i] <= dina_i;
        if (enb_i) dout_q <= mem_q[addrb_i];
    end

    assign doutb_o = dout_q;

endmodule

// File: rtl/m_layer_input_pp.sv
// Ping-pong layer-input buffer for the CNN pipeline.
// One feature map (channel-major c,y,x) is written in arrival order into the
// free bank while the other bank is replayed as KxK windows with stride and
// zero padding over a valid/ready stream.
// Ports:
//   clk_in     - clock
//   rst_n      - asynchronous active-low reset
//   map_in     - input sample, accepted on wr & in_ready
//   wr         - write strobe
//   in_ready   - current write bank is empty
//   map_out    - window sample (0 for padding positions)
//   out_valid  - map_out valid
//   out_ready  - downstream accepts map_out
//   win_last   - last sample of a window
//   frame_last - last sample of the frame
//   ovf        - sticky: wr seen while in_ready was low
module m_layer_input_pp
    import layer_pkg::*;
#(
    parameter int DW     = 16,
    parameter int IN_W   = 88,
    parameter int IN_H   = 88,
    parameter int CH     = 1,
    parameter int K      = 4,
    parameter int STRIDE = 4,
    parameter int PAD    = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] map_in,
    input  logic                 wr,
    output logic                 in_ready,
    output logic signed [DW-1:0] map_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 win_last,
    output logic                 frame_last,
    output logic                 ovf
);

    localparam int OUT_W = out_dim(IN_W, K, STRIDE, PAD);
    localparam int OUT_H = out_dim(IN_H, K, STRIDE, PAD);
    localparam int N     = IN_W * IN_H * CH;
    localparam int AW    = $clog2(N);
    localparam int AW1   = AW + 1;
    localparam int CW    = cw(((IN_W > IN_H) ? IN_W : IN_H) + PAD) + 1;
    localparam int KW    = cw(K);
    localparam int CHW   = cw(CH);
    localparam int OXW   = cw(OUT_W);
    localparam int OYW   = cw(OUT_H);

    // Coordinate and offset constants; all address arithmetic is additive.
    localparam logic signed [CW-1:0] C0    = CW'(-PAD);
    localparam logic signed [CW-1:0] CSTEP = CW'(STRIDE);
    localparam logic [AW1-1:0]       ROW0  = AW1'(-PAD * IN_W);
    localparam logic [AW1-1:0]       ROWS  = AW1'(STRIDE * IN_W);
    localparam logic [AW1-1:0]       BANK1 = AW1'(N);

    // ---------------- writer ----------------
    logic [1:0]    full_q;
    logic          wb_q, rb_q;
    logic [AW-1:0] addr_wr_q;
    logic          ovf_q;
    logic          wr_acc, wr_last, rel;
    logic [AW1-1:0] wr_addr;

    assign in_ready = ~full_q[wb_q];
    assign wr_acc   = wr & in_ready;
    assign wr_last  = (addr_wr_q == AW'(N - 1));
    assign wr_addr  = {1'b0, addr_wr_q} + (wb_q ? BANK1 : '0);
    assign ovf      = ovf_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            addr_wr_q <= '0;
            wb_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (wr && !in_ready) ovf_q <= 1'b1;
            if (wr_acc) begin
                if (wr_last) begin
                    addr_wr_q <= '0;
                    wb_q      <= ~wb_q;
                end else begin
                    addr_wr_q <= addr_wr_q + AW'(1);
                end
            end
        end
    end

    // Writer sets only full[wb], reader clears only full[rb]; they can never
    // target the same bank at one edge because full[wb]=0 and full[rb]=1.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            rb_q   <= 1'b0;
        end else begin
            if (wr_acc && wr_last) full_q[wb_q] <= 1'b1;
            if (rel) begin
                full_q[rb_q] <= 1'b0;
                rb_q         <= ~rb_q;
            end
        end
    end

    // ---------------- reader FSM ----------------
    rd_state_e state_q, state_d;
    logic advance, issue;
    logic vld_p1_q, pad_p1_q, wl_p1_q, fl_p1_q;

    logic [KW-1:0]  kx_q, ky_q;
    logic [CHW-1:0] c_q;
    logic [OXW-1:0] ox_q;
    logic [OYW-1:0] oy_q;
    logic signed [CW-1:0] ix_q, iy_q, wx_q, wy_q;
    logic [AW1-1:0] chan_q, rowoff_q, wrow_q;

    logic kx_end, ky_end, c_end, ox_end, oy_end, frame_end, in_b;
    logic [AW1-1:0] rd_addr;

    assign advance   = ~vld_p1_q | out_ready;
    assign issue     = (state_q == RD_RUN) & advance;
    assign kx_end    = (kx_q == KW'(K - 1));
    assign ky_end    = (ky_q == KW'(K - 1));
    assign c_end     = (c_q == CHW'(CH - 1));
    assign ox_end    = (ox_q == OXW'(OUT_W - 1));
    assign oy_end    = (oy_q == OYW'(OUT_H - 1));
    assign frame_end = kx_end & ky_end & c_end & ox_end & oy_end;
    assign in_b      = ~ix_q[CW-1] & (int'(ix_q) < IN_W) & ~iy_q[CW-1] & (int'(iy_q) < IN_H);
    // Offsets wrap modulo 2^AW1; the sum is exact whenever the point is inside the map.
    assign rd_addr   = chan_q + rowoff_q + AW1'(ix_q) + (rb_q ? BANK1 : '0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= RD_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rel     = 1'b0;
        case (state_q)
            RD_IDLE:  if (full_q[rb_q]) state_d = RD_RUN;
            RD_RUN:   if (issue && frame_end) state_d = RD_DRAIN;
            RD_DRAIN: if (vld_p1_q && out_ready) begin
                rel     = 1'b1;
                state_d = RD_IDLE;
            end
            default:  state_d = RD_IDLE;
        endcase
    end

    // Window walker, innermost first: kx, ky, c, ox, oy.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            kx_q <= '0; ky_q <= '0; c_q <= '0; ox_q <= '0; oy_q <= '0;
            ix_q <= C0; iy_q <= C0; wx_q <= C0; wy_q <= C0;
            chan_q <= '0; rowoff_q <= ROW0; wrow_q <= ROW0;
        end else if (issue) begin
            if (!kx_end) begin
                kx_q <= kx_q + KW'(1);
                ix_q <= ix_q + CW'(1);
            end else if (!ky_end) begin
                kx_q     <= '0;
                ky_q     <= ky_q + KW'(1);
                ix_q     <= wx_q;
                iy_q     <= iy_q + CW'(1);
                rowoff_q <= rowoff_q + AW1'(IN_W);
            end else if (!c_end) begin
                kx_q     <= '0;
                ky_q     <= '0;
                c_q      <= c_q + CHW'(1);
                ix_q     <= wx_q;
                iy_q     <= wy_q;
                rowoff_q <= wrow_q;
                chan_q   <= chan_q + AW1'(IN_W * IN_H);
            end else if (!ox_end) begin
                kx_q     <= '0;
                ky_q     <= '0;
                c_q      <= '0;
                ox_q     <= ox_q + OXW'(1);
                wx_q     <= wx_q + CSTEP;
                ix_q     <= wx_q + CSTEP;
                iy_q     <= wy_q;
                rowoff_q <= wrow_q;
                chan_q   <= '0;
            end else if (!oy_end) begin
                kx_q     <= '0;
                ky_q     <= '0;
                c_q      <= '0;
                ox_q     <= '0;
                oy_q     <= oy_q + OYW'(1);
                wx_q     <= C0;
                ix_q     <= C0;
                wy_q     <= wy_q + CSTEP;
                iy_q     <= wy_q + CSTEP;
                wrow_q   <= wrow_q + ROWS;
                rowoff_q <= wrow_q + ROWS;
                chan_q   <= '0;
            end else begin
                kx_q <= '0; ky_q <= '0; c_q <= '0; ox_q <= '0; oy_q <= '0;
                ix_q <= C0; iy_q <= C0; wx_q <= C0; wy_q <= C0;
                chan_q <= '0; rowoff_q <= ROW0; wrow_q <= ROW0;
            end
        end
    end

    // ---- stage p1: RAM read data and its sideband flags ----
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            pad_p1_q <= 1'b0;
            wl_p1_q  <= 1'b0;
            fl_p1_q  <= 1'b0;
        end else if (advance) begin
            vld_p1_q <= issue;
            pad_p1_q <= ~in_b;
            wl_p1_q  <= issue & kx_end & ky_end;
            fl_p1_q  <= issue & frame_end;
        end
    end

    logic signed [DW-1:0] ram_q;

    conv_pp_ram #(
        .DW   (DW),
        .DEPTH(2 * N),
        .AW1  (AW1)
    ) u_ram (
        .clk_i  (clk_in),
        .wea_i  (wr_acc),
        .addra_i(wr_addr),
        .dina_i (map_in),
        .enb_i  (issue & in_b),
        .addrb_i(rd_addr),
        .doutb_o(ram_q)
    );

    assign map_out    = pad_p1_q ? '0 : ram_q;
    assign out_valid  = vld_p1_q;
    assign win_last   = wl_p1_q;
    assign frame_last = fl_p1_q;

endmodule

// File: tb/tb_m_layer_input_pp.sv
module tb_m_layer_input_pp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_s  [3];
    logic                wr_s   [3];
    logic signed [15:0]  din_s  [3];
    logic                rdy_s  [3];
    logic signed [15:0]  dout_s [3];
    logic                vld_s  [3];
    logic                irdy_s [3];
    logic                wl_s   [3];
    logic                fl_s   [3];
    logic                ovf_s  [3];

    // 0: 4x4 K2 S2 P0 CH1   1: 3x3 K3 S1 P1 CH1   2: 4x4 K2 S2 P0 CH2
    m_layer_input_pp #(.DW(16), .IN_W(4), .IN_H(4), .CH(1), .K(2), .STRIDE(2), .PAD(0)) dA (
        .clk_in(clk), .rst_n(rst_s[0]), .map_in(din_s[0]), .wr(wr_s[0]), .in_ready(irdy_s[0]),
        .map_out(dout_s[0]), .out_valid(vld_s[0]), .out_ready(rdy_s[0]), .win_last(wl_s[0]),
        .frame_last(fl_s[0]), .ovf(ovf_s[0]));
    m_layer_input_pp #(.DW(16), .IN_W(3), .IN_H(3), .CH(1), .K(3), .STRIDE(1), .PAD(1)) dB (
        .clk_in(clk), .rst_n(rst_s[1]), .map_in(din_s[1]), .wr(wr_s[1]), .in_ready(irdy_s[1]),
        .map_out(dout_s[1]), .out_valid(vld_s[1]), .out_ready(rdy_s[1]), .win_last(wl_s[1]),
        .frame_last(fl_s[1]), .ovf(ovf_s[1]));
    m_layer_input_pp #(.DW(16), .IN_W(4), .IN_H(4), .CH(2), .K(2), .STRIDE(2), .PAD(0)) dC (
        .clk_in(clk), .rst_n(rst_s[2]), .map_in(din_s[2]), .wr(wr_s[2]), .in_ready(irdy_s[2]),
        .map_out(dout_s[2]), .out_valid(vld_s[2]), .out_ready(rdy_s[2]), .win_last(wl_s[2]),
        .frame_last(fl_s[2]), .ovf(ovf_s[2]));

    int n_vec = 0;
    int n_err = 0;
    bit bp_en = 1'b0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] q2[$];

    int expA[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ent(input int v, input bit w, input bit f);
        return {f, w, v[15:0]};
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [17:0] qget(input int d, input int i);
        if (i >= qsize(d)) return '1;
        case (d)
            0: return q0[i];
            1: return q1[i];
            default: return q2[i];
        endcase
    endfunction

    // Accepted-sample capture, plus hold check while stalled under backpressure.
    always @(negedge clk) begin
        if (bp_en && vld_s[0] && !rdy_s[0] && q0.size() < 16)
            check_vec("stall_hold", 32'(dout_s[0]), 32'(expA[q0.size()]));
        if (vld_s[0] && rdy_s[0]) q0.push_back({fl_s[0], wl_s[0], dout_s[0]});
        if (vld_s[1] && rdy_s[1]) q1.push_back({fl_s[1], wl_s[1], dout_s[1]});
        if (vld_s[2] && rdy_s[2]) q2.push_back({fl_s[2], wl_s[2], dout_s[2]});
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            rdy_s[0] = 1'($urandom_range(0, 1));
        end
    end

    task automatic write_frame(input int d, input int base, input int n, input bit chk);
        for (int i = 0; i < n; i++) begin
            if (chk) check_vec($sformatf("in_ready_w%0d", i), 32'(irdy_s[d]), 32'd1);
            din_s[d] = 16'(base + i);
            wr_s[d]  = 1'b1;
            @(posedge clk); #1;
        end
        wr_s[d] = 1'b0;
    endtask

    task automatic wait_samples(input int d, input int n, input int budget);
        int cyc = 0;
        while (qsize(d) < n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check_vec($sformatf("count_d%0d", d), 32'(qsize(d)), 32'(n));
    endtask

    task automatic check_seq_a(input string tag, input int off, input int base);
        for (int i = 0; i < 16; i++)
            check_vec($sformatf("%s[%0d]", tag, i), 32'(qget(0, off + i)),
                      32'(ent(expA[i] + base, (i % 4) == 3, i == 15)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int pb_first[9] = '{0, 0, 0, 0, 1, 2, 0, 4, 5};
    int pb_last[9]  = '{5, 6, 0, 8, 9, 0, 0, 0, 0};
    int pc_first[8] = '{0, 1, 4, 5, 100, 101, 104, 105};
    int pc_last[8]  = '{10, 11, 14, 15, 110, 111, 114, 115};

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b0; wr_s[d] = 1'b0; din_s[d] = '0; rdy_s[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_vec($sformatf("rst_in_ready_d%0d", d), 32'(irdy_s[d]), 32'd1);
            check_vec($sformatf("rst_valid_d%0d", d), 32'(vld_s[d]), 32'd0);
            check_vec($sformatf("rst_ovf_d%0d", d), 32'(ovf_s[d]), 32'd0);
        end
        check_vec("rst_win_last", 32'(wl_s[0]), 32'd0);
        check_vec("rst_frame_last", 32'(fl_s[0]), 32'd0);
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b1;
        @(posedge clk); #1;

        // Basic 4x4 K2 S2 frame and first-sample latency.
        write_frame(0, 0, 16, 1'b0);
        check_vec("lat_e0", 32'(vld_s[0]), 32'd0);
        @(posedge clk); #1;
        check_vec("lat_e1", 32'(vld_s[0]), 32'd0);
        @(posedge clk); #1;
        check_vec("lat_e2", 32'(vld_s[0]), 32'd1);
        wait_samples(0, 16, 100);
        check_seq_a("basic", 0, 0);
        check_vec("idle_valid", 32'(vld_s[0]), 32'd0);

        // Padded 3x3 K3 S1 P1.
        write_frame(1, 1, 9, 1'b0);
        wait_samples(1, 81, 300);
        for (int i = 0; i < 9; i++) begin
            check_vec($sformatf("pad_first[%0d]", i), 32'(qget(1, i)), 32'(ent(pb_first[i], i == 8, 1'b0)));
            check_vec($sformatf("pad_mid[%0d]", i), 32'(qget(1, 36 + i)), 32'(ent(i + 1, i == 8, 1'b0)));
            check_vec($sformatf("pad_last[%0d]", i), 32'(qget(1, 72 + i)), 32'(ent(pb_last[i], i == 8, i == 8)));
        end

        // Two channels.
        write_frame(2, 0, 16, 1'b0);
        write_frame(2, 100, 16, 1'b0);
        wait_samples(2, 32, 200);
        for (int i = 0; i < 8; i++) begin
            check_vec($sformatf("ch_first[%0d]", i), 32'(qget(2, i)), 32'(ent(pc_first[i], (i % 4) == 3, 1'b0)));
            check_vec($sformatf("ch_last[%0d]", i), 32'(qget(2, 24 + i)), 32'(ent(pc_last[i], (i % 4) == 3, i == 7)));
        end

        // Random backpressure.
        q0.delete();
        bp_en = 1'b1;
        write_frame(0, 0, 16, 1'b0);
        wait_samples(0, 16, 400);
        bp_en = 1'b0;
        #2;
        rdy_s[0] = 1'b1;
        @(posedge clk); #1;
        check_seq_a("bp", 0, 0);

        // Ping-pong: A then B back to back, third frame must wait.
        q0.delete();
        write_frame(0, 0, 16, 1'b1);
        write_frame(0, 200, 16, 1'b1);
        check_vec("pp_stall_ready", 32'(irdy_s[0]), 32'd0);
        din_s[0] = 16'sd999;
        wr_s[0]  = 1'b1;
        @(posedge clk); #1;
        wr_s[0]  = 1'b0;
        check_vec("pp_ovf", 32'(ovf_s[0]), 32'd1);
        begin
            int cyc = 0;
            while (!irdy_s[0] && cyc < 60) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_vec("pp_ready_rise", 32'(irdy_s[0]), 32'd1);
        check_vec("pp_A_done_first", 32'(q0.size() >= 16), 32'd1);
        write_frame(0, 300, 16, 1'b0);
        wait_samples(0, 48, 400);
        check_seq_a("ppA", 0, 0);
        check_seq_a("ppB", 16, 200);
        check_seq_a("ppC", 32, 300);

        // Asynchronous reset in the middle of a read.
        q0.delete();
        write_frame(0, 0, 16, 1'b0);
        begin
            int cyc = 0;
            while (q0.size() < 5 && cyc < 60) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        #2;
        rst_s[0] = 1'b0;
        #1;
        check_vec("arst_valid", 32'(vld_s[0]), 32'd0);
        check_vec("arst_in_ready", 32'(irdy_s[0]), 32'd1);
        check_vec("arst_ovf", 32'(ovf_s[0]), 32'd0);
        @(posedge clk); #1;
        rst_s[0] = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        write_frame(0, 50, 16, 1'b0);
        wait_samples(0, 16, 100);
        check_seq_a("after_rst", 0, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m_layer_input_pp.md
Name: m_layer_input_pp

Overview:
- Parametrised successor to the single-buffer layer-input block for the CNN pipeline.
- Captures one input feature map, multi-channel, in arrival order into a double-buffered (ping-pong) RAM.
- Replays it as a stream of KxK convolution/pooling windows with configurable stride and zero padding.
- Output uses a valid/ready handshake, so the next layer can apply backpressure while the following frame is written into the other bank.

Parameters:
- DW, 16, sample width (signed).
- IN_W, 88, input map width.
- IN_H, 88, input map height.
- CH, 1, channels per map; stored channel-major (c, y, x).
- K, 4, kernel/pool edge size (>=1).
- STRIDE, 4, window step in x and y (>=1).
- PAD, 0, zero border on all four sides (0..K-1).
- Derived localparams: OUT_W=(IN_W+2*PAD-K)/STRIDE+1, OUT_H likewise, N=IN_W*IN_H*CH, AW=$clog2(N).

Ports:
- clk_in, input, 1, sole clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- map_in, input, DW, input sample.
- wr, input, 1, write strobe; the sample is accepted when wr&in_ready.
- in_ready, output, 1, the current write bank is empty.
- map_out, output, DW, window sample.
- out_valid, output, 1, map_out is valid.
- out_ready, input, 1, downstream accepts map_out.
- win_last, output, 1, last sample of the current window.
- frame_last, output, 1, last sample of the last window of the frame.
- ovf, output, 1, sticky flag: wr seen while in_ready=0.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, win_last, frame_last and ovf clear to 0. in_ready resets to 1.
  - Both banks are marked EMPTY; write and read bank pointers are 0; all counters are 0.
  - RAM contents are not cleared. Reset mid-frame discards both the partial write and the partial read.
- Bank state: each bank is EMPTY or FULL, one flag per bank.
- Writer:
  - addr_wr increments on each accepted write.
  - On the write with addr_wr==N-1, at the same edge: mark bank[wb] FULL, clear addr_wr, toggle wb.
  - in_ready = ~full[wb]. It is registered-state-derived; there is no combinational path from any input.
- Write while in_ready=0: the sample is dropped, no state changes, and ovf sets and stays set until reset.
- Reader FSM, states IDLE / RUN / DRAIN:
  - IDLE -> RUN when full[rb].
  - RUN issues one address per advance cycle, where advance = ~out_valid | out_ready.
  - Loop order, innermost first: kx, ky, c, ox, oy.
  - Source coordinate: ix = ox*STRIDE+kx-PAD, iy = oy*STRIDE+ky-PAD.
  - If ix or iy is outside the map, there is no RAM read and a registered pad flag forces map_out=0.
  - Otherwise addr = rb*N + c*IN_W*IN_H + iy*IN_W + ix.
  - All offsets are formed by incremental adders. No multipliers in the address path.
  - After the final address is issued: RUN -> DRAIN.
  - DRAIN: when the final sample is accepted (out_valid&out_ready), clear full[rb], toggle rb, and go to IDLE.
- Read pipeline:
  - One-cycle synchronous RAM; the read enable is gated by advance.
  - When stalled, the output register and address counters hold, so no sample is lost or repeated.
  - win_last and frame_last travel with their sample.
- Latency:
  - Edge E0 captures the final write. After E1 the FSM is in RUN. After E2, out_valid=1 with the first sample.
  - With out_ready held high, the stream is one sample per cycle, OUT_W*OUT_H*CH*K*K samples per frame, with no bubbles inside a frame.
- Simultaneous events:
  - The writer filling bank A and the reader releasing bank B at the same edge are independent.
  - If the reader releases the bank equal to wb, in_ready rises on the next cycle.
  - Writes into bank wb never touch bank rb while that bank is FULL.
- Widths: the internal address is AW+1 bits (bank bit MSB). Coordinate counters are signed, $clog2(max(IN_W,IN_H)+PAD)+1 bits wide.

Decomposition:
- Shared package layer_pkg: reader FSM state enum, a clog2-based width helper, and the OUT_W/OUT_H formula as a function, so downstream layers size themselves identically.
- One sub-module: conv_pp_ram, a simple dual-port inferred RAM of 2*N x DW with write port A, read port B, enb, and one-cycle registered read.

Test Plan:
- Config IN_W=IN_H=4, CH=1, K=2, STRIDE=2, PAD=0. Write 0..15, out_ready=1 -> 16 samples: 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15. win_last on every 4th sample, frame_last on the 16th. out_valid rises 2 edges after the last write.
- Config IN_W=IN_H=3, K=3, STRIDE=1, PAD=1. Write 1..9 -> first window 0,0,0,0,1,2,0,4,5. Last window 5,6,0,8,9,0,0,0,0. 81 samples total.
- Config CH=2, 4x4, K=2, S=2. Ch0 = 0..15, ch1 = 100..115 -> first window 0,1,4,5,100,101,104,105.
- Backpressure: toggle out_ready pseudo-randomly during the first test -> identical 16-sample sequence with no duplicates or drops; map_out is stable while out_valid&~out_ready.
- Ping-pong: write frame A, then frame B immediately while A is being read -> in_ready stays 1 through B. A third frame stalls (in_ready=0) until A's frame_last is accepted. A wr while stalled sets ovf=1 and the sample is dropped.
- Assert rst_n low mid-read for 1 cycle -> out_valid=0 and in_ready=1 immediately (async). A fresh frame then reads correctly from bank 0.
